// File: rtl/stream_demux.sv
// One-to-N packet demultiplexer with a single output register stage.
// Packets whose destination index is out of range are consumed and counted.
//
// state | meaning
// IDLE  | no packet open; destination comes from sel
// ROUTE | packet open, beats go to the latched destination
// DROP  | packet open, beats are consumed and discarded
module stream_demux #(
    parameter int WIDTH     = 32,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [SEL_WIDTH-1:0]       sel,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [N_OUTPUTS*WIDTH-1:0] m_tdata,
    output logic [N_OUTPUTS-1:0]       m_tvalid,
    output logic [N_OUTPUTS-1:0]       m_tlast,
    input  logic [N_OUTPUTS-1:0]       m_tready,
    output logic [31:0]                drop_count
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    localparam logic [SEL_WIDTH:0] N_OUT = (SEL_WIDTH+1)'(N_OUTPUTS);

    state_t               state;
    logic [SEL_WIDTH-1:0] dest;
    logic [SEL_WIDTH-1:0] out_dest;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_last;

    logic                 sel_ok;
    logic                 discard;
    logic [SEL_WIDTH-1:0] eff_dest;
    logic                 dest_ready;
    logic                 drain;
    logic                 accept;
    logic                 load;

    assign sel_ok   = {1'b0, sel} < N_OUT;
    assign discard  = (state == DROP) || ((state == IDLE) && !sel_ok);
    assign eff_dest = (state == IDLE) ? sel : dest;

    // Only the ready of the output currently holding the register matters.
    always_comb begin
        dest_ready = 1'b0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (out_dest == SEL_WIDTH'(i)) dest_ready = m_tready[i];
        end
    end

    assign drain    = out_valid && dest_ready;
    assign s_tready = discard || !out_valid || dest_ready;
    assign accept   = s_tvalid && s_tready;
    assign load     = accept && !discard;

    for (genvar g = 0; g < N_OUTPUTS; g++) begin : g_out
        assign m_tvalid[g]                = out_valid && (out_dest == SEL_WIDTH'(g));
        assign m_tlast[g]                 = m_tvalid[g] && out_last;
        assign m_tdata[g*WIDTH +: WIDTH]  = out_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            dest       <= '0;
            out_dest   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= s_tdata;
                out_last  <= s_tlast;
                out_dest  <= eff_dest;
            end else if (drain) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!s_tlast) begin
                            state <= sel_ok ? ROUTE : DROP;
                            dest  <= sel;
                        end
                    end
                    default: begin
                        if (s_tlast) state <= IDLE;
                    end
                endcase
            end

            if (accept && discard && s_tlast && (drop_count != 32'hFFFF_FFFF))
                drop_count <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based packet model.
module tb_stream_demux;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [SW-1:0]    sel;
    logic [W-1:0]     s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [N*W-1:0]   m_tdata;
    logic [N-1:0]     m_tvalid;
    logic [N-1:0]     m_tlast;
    logic [N-1:0]     m_tready;
    logic [31:0]      drop_count;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(W), .N_OUTPUTS(N), .SEL_WIDTH(SW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sel        (sel),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           dest;
    } beat_t;

    // Model: the registered beat is a queue of at most one entry; the open
    // packet is described by whether it is open, dropped, and where it goes.
    beat_t       pipe[$];
    bit          pkt_open;
    bit          pkt_drop;
    int          pkt_dest;
    logic [31:0] mdl_drops;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        pkt_open  = 1'b0;
        pkt_drop  = 1'b0;
        pkt_dest  = 0;
        mdl_drops = '0;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit l,
                         input logic [SW-1:0] s, input logic [N-1:0] r);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        sel      = s;
        m_tready = r;
    endtask

    // Called at posedge+1 with inputs already driven; compares, advances the
    // model over the coming edge, and returns at the next posedge+1.
    task automatic tick();
        bit          in_drop;
        bit          busy;
        bit          drains;
        bit          exp_ready;
        logic [N-1:0] ev;
        logic [N-1:0] el;
        beat_t       b;
        #3;
        in_drop   = pkt_open ? pkt_drop : (int'(sel) >= N);
        busy      = pipe.size() > 0;
        drains    = 1'b0;
        ev        = '0;
        el        = '0;
        if (busy) begin
            drains          = m_tready[pipe[0].dest];
            ev[pipe[0].dest] = 1'b1;
            el[pipe[0].dest] = pipe[0].last;
        end
        exp_ready = in_drop || !busy || drains;

        check("s_tready",   64'(s_tready),   64'(exp_ready));
        check("m_tvalid",   64'(m_tvalid),   64'(ev));
        check("m_tlast",    64'(m_tlast),    64'(el));
        check("drop_count", 64'(drop_count), 64'(mdl_drops));
        if (busy) begin
            for (int i = 0; i < N; i++)
                check("m_tdata", 64'(m_tdata[i*W +: W]), 64'(pipe[0].data));
        end

        if (drains) void'(pipe.pop_front());
        if (s_tvalid && exp_ready) begin
            if (in_drop) begin
                if (s_tlast && mdl_drops != 32'hFFFF_FFFF) mdl_drops = mdl_drops + 1;
            end else begin
                b.data = s_tdata;
                b.last = s_tlast;
                b.dest = pkt_open ? pkt_dest : int'(sel);
                pipe.push_back(b);
            end
            if (!pkt_open && !s_tlast) begin
                pkt_open = 1'b1;
                pkt_drop = in_drop;
                pkt_dest = int'(sel);
            end else if (pkt_open && s_tlast) begin
                pkt_open = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp38[3];
        logic [SW-1:0] sel38[3];
        int  idx;
        bit  acc;

        exp38[0] = 3'b001; exp38[1] = 3'b100; exp38[2] = 3'b010;
        sel38[0] = 2'd0;   sel38[1] = 2'd2;   sel38[2] = 2'd1;

        resetn = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        model_reset();
        #12;
        check("rst_m_tvalid",   64'(m_tvalid),   64'd0);
        check("rst_m_tlast",    64'(m_tlast),    64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_m_tdata",    64'(m_tdata[W-1:0]), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Four-beat packet to output 1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + i, i == 3, 2'd1, 3'b111);
            tick();
            check("p34_valid", 64'(m_tvalid), 64'b010);
            check("p34_data",  64'(m_tdata[W +: W]), 64'(32'hA0 + i));
            check("p34_last",  64'(m_tlast), (i == 3) ? 64'b010 : 64'b000);
        end
        drive(1'b0, '0, 1'b0, 2'd1, 3'b111);
        tick();
        check("p34_idle", 64'(m_tvalid), 64'd0);

        // sel changes mid-packet are ignored; next packet follows new sel
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hB0 + i, i == 3, (i < 2) ? 2'd1 : 2'd2, 3'b111);
            tick();
            check("p35_valid", 64'(m_tvalid), 64'b010);
        end
        drive(1'b1, 32'hC0, 1'b1, 2'd2, 3'b111);
        tick();
        check("p35_next_valid", 64'(m_tvalid), 64'b100);
        check("p35_next_data",  64'(m_tdata[2*W +: W]), 64'h C0);
        drive(1'b0, '0, 1'b0, 2'd2, 3'b111);
        tick();

        // Out-of-range destination: consumed silently and counted once
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hD0 + i, i == 2, 2'd3, 3'b000);
            #2;
            check("p36_ready", 64'(s_tready), 64'd1);
            tick();
            check("p36_valid", 64'(m_tvalid), 64'd0);
            check("p36_drops", 64'(drop_count), (i == 2) ? 64'd1 : 64'd0);
        end

        // Back-pressure on output 0 for five cycles
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive(idx < 4, 32'hE0 + idx, idx == 3, 2'd0, (cyc < 5) ? 3'b110 : 3'b111);
            #2;
            acc = s_tvalid && s_tready;
            if (cyc >= 1 && cyc <= 4) begin
                check("p37_stall_ready", 64'(s_tready), 64'd0);
                check("p37_hold_data",   64'(m_tdata[W-1:0]), 64'h E0);
                check("p37_hold_valid",  64'(m_tvalid), 64'b001);
            end
            tick();
            if (acc) idx++;
        end
        check("p37_all_sent", 64'(idx), 64'd4);

        // Back-to-back single-beat packets to 0, 2, 1
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hF0 + k, 1'b1, sel38[k], 3'b111);
            tick();
            check("p38_valid", 64'(m_tvalid), 64'(exp38[k]));
            check("p38_last",  64'(m_tlast),  64'(exp38[k]));
        end
        drive(1'b0, '0, 1'b0, 2'd0, 3'b111);
        tick();

        // Reset pulse mid-packet with a beat held in the register
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h10 + i, 1'b0, 2'd1, 3'b000);
            tick();
        end
        check("p39_pre_valid", 64'(m_tvalid), 64'b010);
        #1;
        resetn = 1'b0;
        #1;
        check("p39_rst_valid", 64'(m_tvalid),   64'd0);
        check("p39_rst_drops", 64'(drop_count), 64'd0);
        model_reset();
        #1;
        resetn = 1'b1;
        drive(1'b1, 32'h20, 1'b1, 2'd2, 3'b111);
        tick();
        check("p39_after_valid", 64'(m_tvalid), 64'b100);
        check("p39_after_data",  64'(m_tdata[2*W +: W]), 64'h20);
        drive(1'b0, '0, 1'b0, 2'd0, 3'b111);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                  SW'($urandom_range(0, 3)), r);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
